// File: rtl/seq_loader.sv
// Sequence loader ahead of the alignment generator: buffers sequences A and B, drives start, latches the result.
// Optional build macro SEQ_LOADER_CYCLE_COUNT_EN enables the run_cycles counter (otherwise tied to 0).
module seq_loader #(
    parameter int SYM_W   = 2,
    parameter int MAX_LEN = 64,
    parameter int LEN_W   = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SYM_W-1:0] in_sym,
    input  logic             in_last,
    output logic [LEN_W-1:0] len_a,
    output logic [LEN_W-1:0] len_b,
    input  logic [LEN_W-1:0] rd_addr_a,
    output logic [SYM_W-1:0] rd_data_a,
    input  logic [LEN_W-1:0] rd_addr_b,
    output logic [SYM_W-1:0] rd_data_b,
    output logic             gen_start,
    input  logic             gen_finish,
    input  logic [31:0]      gen_solution,
    output logic [31:0]      result,
    output logic             result_valid,
    input  logic             result_ack,
    output logic             ovf,
    output logic [31:0]      run_cycles,
    output logic [1:0]       dbg_state
);

    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] ONE_L     = LEN_W'(1);

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        RUN    = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] len_a_q, len_a_d, len_b_q, len_b_d;
    logic             ovf_q, ovf_d;
    logic             gen_start_q, gen_start_d;
    logic [31:0]      result_q, result_d;
    logic             result_valid_q, result_valid_d;
    logic [SYM_W-1:0] rd_data_a_q, rd_data_a_d, rd_data_b_q, rd_data_b_d;
    logic             wr_a, wr_b, xfer;

    logic [SYM_W-1:0] mem_a [MAX_LEN];
    logic [SYM_W-1:0] mem_b [MAX_LEN];

    // Stream handshake: a symbol moves on a rising edge where in_valid && in_ready;
    // in_ready is high exactly while loading A or B, and in_sym/in_last matter only on a transfer.
    assign in_ready = (state_q == LOAD_A) || (state_q == LOAD_B);
    assign xfer     = in_valid && in_ready;

    always_comb begin
        state_d        = state_q;
        len_a_d        = len_a_q;
        len_b_d        = len_b_q;
        ovf_d          = ovf_q;
        gen_start_d    = 1'b0;
        result_d       = result_q;
        result_valid_d = result_valid_q;
        wr_a           = 1'b0;
        wr_b           = 1'b0;
        case (state_q)
            LOAD_A: begin
                if (xfer) begin
                    // Beyond MAX_LEN the symbol is dropped but the transfer still completes.
                    if (len_a_q < MAX_LEN_L) begin
                        wr_a    = 1'b1;
                        len_a_d = len_a_q + ONE_L;
                    end else begin
                        ovf_d = 1'b1;
                    end
                    if (in_last) state_d = LOAD_B;
                end
            end
            LOAD_B: begin
                if (xfer) begin
                    if (len_b_q < MAX_LEN_L) begin
                        wr_b    = 1'b1;
                        len_b_d = len_b_q + ONE_L;
                    end else begin
                        ovf_d = 1'b1;
                    end
                    if (in_last) begin
                        state_d     = RUN;
                        gen_start_d = 1'b1;
                    end
                end
            end
            RUN: begin
                gen_start_d = 1'b1;
                if (gen_finish) begin
                    result_d       = gen_solution;
                    result_valid_d = 1'b1;
                    gen_start_d    = 1'b0;
                    state_d        = DONE;
                end
            end
            DONE: begin
                if (result_ack) begin
                    result_valid_d = 1'b0;
                    len_a_d        = '0;
                    len_b_d        = '0;
                    ovf_d          = 1'b0;
                    state_d        = LOAD_A;
                end
            end
            default: state_d = LOAD_A;
        endcase
        // Reads compare against the pre-edge length, so a same-edge write is never visible.
        rd_data_a_d = (rd_addr_a < len_a_q) ? mem_a[rd_addr_a[AW-1:0]] : '0;
        rd_data_b_d = (rd_addr_b < len_b_q) ? mem_b[rd_addr_b[AW-1:0]] : '0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= LOAD_A;
            len_a_q        <= '0;
            len_b_q        <= '0;
            ovf_q          <= 1'b0;
            gen_start_q    <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            rd_data_a_q    <= '0;
            rd_data_b_q    <= '0;
        end else begin
            state_q        <= state_d;
            len_a_q        <= len_a_d;
            len_b_q        <= len_b_d;
            ovf_q          <= ovf_d;
            gen_start_q    <= gen_start_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            rd_data_a_q    <= rd_data_a_d;
            rd_data_b_q    <= rd_data_b_d;
        end
    end

    // Storage arrays keep their contents through reset.
    always_ff @(posedge clk) begin
        if (wr_a) mem_a[len_a_q[AW-1:0]] <= in_sym;
        if (wr_b) mem_b[len_b_q[AW-1:0]] <= in_sym;
    end

`ifdef SEQ_LOADER_CYCLE_COUNT_EN
    logic [31:0] run_cycles_q, run_cycles_d;

    always_comb begin
        run_cycles_d = run_cycles_q;
        if (state_q == RUN)      run_cycles_d = run_cycles_q + 32'd1;
        else if (state_d == RUN) run_cycles_d = '0;
    end

    always_ff @(posedge clk) begin
        if (!reset) run_cycles_q <= '0;
        else        run_cycles_q <= run_cycles_d;
    end

    assign run_cycles = run_cycles_q;
`else
    assign run_cycles = '0;
`endif

    assign len_a        = len_a_q;
    assign len_b        = len_b_q;
    assign ovf          = ovf_q;
    assign gen_start    = gen_start_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign rd_data_a    = rd_data_a_q;
    assign rd_data_b    = rd_data_b_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_seq_loader.sv
// Bench for seq_loader: random jobs against a queue-based model, a model generator core and a result scoreboard.
module tb_seq_loader;
  localparam int SYM_W   = 2;
  localparam int MAX_LEN = 64;
  localparam int LEN_W   = 7;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic in_valid = 1'b0, in_last = 1'b0, result_ack = 1'b0;
  logic [SYM_W-1:0] in_sym = '0;
  logic [LEN_W-1:0] rd_addr_a = '0, rd_addr_b = '0;
  logic in_ready, gen_start, gen_finish, result_valid, ovf;
  logic [LEN_W-1:0] len_a, len_b;
  logic [SYM_W-1:0] rd_data_a, rd_data_b;
  logic [31:0] gen_solution, result, run_cycles;
  logic [1:0] dbg_state;

  logic core_finish = 1'b0, spur_finish = 1'b0;
  logic [31:0] core_sol_out = '0, spur_sol = '0, core_sol = '0;
  int core_lat = 1;

  assign gen_finish   = core_finish | spur_finish;
  assign gen_solution = spur_finish ? spur_sol : core_sol_out;

  typedef struct packed {
    logic [31:0] res;
    logic [31:0] cyc;
    logic [6:0]  la;
    logic [6:0]  lb;
    logic        ovf;
  } exp_t;

  exp_t exp_q[$];
  logic [1:0] model_a[$];
  logic [1:0] model_b[$];
  int n_checks = 0;
  int n_fails = 0;

  seq_loader #(.SYM_W(SYM_W), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_sym(in_sym), .in_last(in_last),
    .len_a(len_a), .len_b(len_b),
    .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a),
    .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b),
    .gen_start(gen_start), .gen_finish(gen_finish), .gen_solution(gen_solution),
    .result(result), .result_valid(result_valid), .result_ack(result_ack),
    .ovf(ovf), .run_cycles(run_cycles), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // model generator core: finishes core_lat edges after it sees start, aborts if start drops
  initial begin
    forever begin
      @(negedge clk);
      if (gen_start) begin
        int k;
        bit aborted;
        k = 1;
        aborted = 1'b0;
        while (k < core_lat && !aborted) begin
          @(negedge clk);
          if (!gen_start) aborted = 1'b1;
          k++;
        end
        if (!aborted) begin
          core_finish  = 1'b1;
          core_sol_out = core_sol;
          @(negedge clk);
          core_finish = 1'b0;
        end
      end
    end
  end

  // scoreboard monitor: pops one expectation on every rising result_valid
  initial begin
    logic rv_prev;
    rv_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (result_valid && !rv_prev) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fails++;
          $display("FAIL unexpected_result: got 0x%0h with no job outstanding", result);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("result", result, e.res);
          check("run_cycles", run_cycles, e.cyc);
          check("len_a_at_done", len_a, e.la);
          check("len_b_at_done", len_b, e.lb);
          check("ovf_at_done", ovf, e.ovf);
          check("gen_start_at_done", gen_start, 0);
          check("in_ready_at_done", in_ready, 0);
        end
      end
      rv_prev = result_valid;
    end
  end

  // driver tasks
  task automatic send_sym(input logic [1:0] s, input logic last);
    int g;
    @(negedge clk);
    in_valid = 1'b1;
    in_sym   = s;
    in_last  = last;
    g = 0;
    while (!in_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (!in_ready) check("in_ready_wait", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle(input int gap);
    int n;
    n = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_job(input logic [1:0] qa[$], input logic [1:0] qb[$], input int gap,
                        input int lat, input logic [31:0] sol);
    exp_t e;
    int w;
    model_a.delete();
    model_b.delete();
    foreach (qa[i]) if (model_a.size() < MAX_LEN) model_a.push_back(qa[i]);
    foreach (qb[i]) if (model_b.size() < MAX_LEN) model_b.push_back(qb[i]);
    e.res = sol;
`ifdef SEQ_LOADER_CYCLE_COUNT_EN
    e.cyc = 32'(lat);
`else
    e.cyc = 32'd0;
`endif
    e.la  = 7'(model_a.size());
    e.lb  = 7'(model_b.size());
    e.ovf = (qa.size() > MAX_LEN) || (qb.size() > MAX_LEN);
    exp_q.push_back(e);
    core_lat = lat;
    core_sol = sol;
    foreach (qa[i]) begin
      send_sym(qa[i], i == qa.size() - 1);
      idle(gap);
    end
    foreach (qb[i]) begin
      if (i == qb.size() - 1) begin
        @(negedge clk);
        check("gen_start_before_last_b", gen_start, 0);
        check("len_a_loaded", len_a, e.la);
        send_sym(qb[i], 1'b1);
      end else begin
        send_sym(qb[i], 1'b0);
        idle(gap);
      end
    end
    @(negedge clk);
    check("gen_start_after_last_b", gen_start, 1);
    check("in_ready_in_run", in_ready, 0);
    w = 0;
    while (!result_valid && w < lat + 50) begin
      @(negedge clk);
      w++;
    end
    check("result_valid_seen", result_valid, 1);
  endtask

  task automatic rd_check(input logic [6:0] aa, input logic [6:0] ab);
    logic [1:0] ea, eb;
    @(negedge clk);
    rd_addr_a = aa;
    rd_addr_b = ab;
    ea = (int'(aa) < model_a.size()) ? model_a[aa] : 2'd0;
    eb = (int'(ab) < model_b.size()) ? model_b[ab] : 2'd0;
    @(negedge clk);
    check("rd_data_a", rd_data_a, ea);
    check("rd_data_b", rd_data_b, eb);
  endtask

  task automatic ack_job(input logic [31:0] sol, input int hold);
    repeat (hold) begin
      @(negedge clk);
      check("result_hold", result, sol);
      check("in_ready_done", in_ready, 0);
      check("result_valid_hold", result_valid, 1);
    end
    @(negedge clk);
    result_ack = 1'b1;
    @(negedge clk);
    result_ack = 1'b0;
    check("result_valid_after_ack", result_valid, 0);
    check("in_ready_after_ack", in_ready, 1);
    check("len_a_after_ack", len_a, 0);
    check("len_b_after_ack", len_b, 0);
    check("ovf_after_ack", ovf, 0);
    check("state_after_ack", dbg_state, 2'd0);
    check("result_kept_after_ack", result, sol);
  endtask

  initial begin
    logic [1:0] qa[$];
    logic [1:0] qb[$];
    logic [31:0] sol;

    // reset
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_state", dbg_state, 2'd0);
    check("rst_len_a", len_a, 0);
    check("rst_len_b", len_b, 0);
    check("rst_gen_start", gen_start, 0);
    check("rst_result", result, 0);
    check("rst_result_valid", result_valid, 0);
    check("rst_ovf", ovf, 0);
    check("rst_run_cycles", run_cycles, 0);
    check("rst_rd_data_a", rd_data_a, 0);
    check("rst_rd_data_b", rd_data_b, 0);
    reset = 1'b1;

    // directed job: A={0,1,2,3}, B={3,2,1}, core finishes after 10 cycles with 7
    qa = '{2'd0, 2'd1, 2'd2, 2'd3};
    qb = '{2'd3, 2'd2, 2'd1};
    do_job(qa, qb, 0, 10, 32'd7);
    rd_check(7'd2, 7'd3);
    rd_check(7'd5, 7'd0);
    rd_check(7'd3, 7'd2);
    ack_job(32'd7, 5);

    // spurious finish and ack while loading are ignored
    @(negedge clk);
    spur_sol    = $urandom;
    spur_finish = 1'b1;
    result_ack  = 1'b1;
    @(negedge clk);
    spur_finish = 1'b0;
    result_ack  = 1'b0;
    check("spur_result_valid", result_valid, 0);
    check("spur_result", result, 32'd7);
    check("spur_state", dbg_state, 2'd0);
    check("spur_in_ready", in_ready, 1);
    check("spur_gen_start", gen_start, 0);

    // overflow: 66 symbols for A
    qa.delete();
    qb.delete();
    for (int i = 0; i < 66; i++) qa.push_back(2'($urandom_range(0, 3)));
    for (int i = 0; i < 5; i++) qb.push_back(2'($urandom_range(0, 3)));
    sol = $urandom;
    do_job(qa, qb, 0, 4, sol);
    rd_check(7'd63, 7'd4);
    rd_check(7'd64, 7'd5);
    ack_job(sol, 1);

    // in_valid toggling every other cycle: A={1,1}, B={2}
    qa = '{2'd1, 2'd1};
    qb = '{2'd2};
    sol = $urandom;
    do_job(qa, qb, 1, 3, sol);
    rd_check(7'd0, 7'd0);
    rd_check(7'd1, 7'd1);
    rd_check(7'd2, 7'd0);
    ack_job(sol, 2);

    // random jobs
    for (int j = 0; j < 5; j++) begin
      int na, nb;
      qa.delete();
      qb.delete();
      na = $urandom_range(1, 70);
      nb = $urandom_range(1, 70);
      for (int i = 0; i < na; i++) qa.push_back(2'($urandom_range(0, 3)));
      for (int i = 0; i < nb; i++) qb.push_back(2'($urandom_range(0, 3)));
      sol = $urandom;
      do_job(qa, qb, -1, $urandom_range(1, 25), sol);
      for (int r = 0; r < 4; r++)
        rd_check(7'($urandom_range(0, 70)), 7'($urandom_range(0, 70)));
      ack_job(sol, $urandom_range(0, 3));
    end

    // reset while running aborts the job
    core_lat = 200;
    send_sym(2'd1, 1'b1);
    send_sym(2'd2, 1'b1);
    repeat (3) @(negedge clk);
    check("run_state", dbg_state, 2'd2);
    check("run_gen_start", gen_start, 1);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("abort_gen_start", gen_start, 0);
    check("abort_state", dbg_state, 2'd0);
    check("abort_in_ready", in_ready, 1);
    check("abort_len_a", len_a, 0);
    check("abort_len_b", len_b, 0);
    check("abort_result_valid", result_valid, 0);
    check("abort_run_cycles", run_cycles, 0);
    repeat (4) @(negedge clk);
    check("abort_stays_idle", dbg_state, 2'd0);

    check("exp_q_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
